pc_unit: RTL and testbench

//  Program-counter stage directly downstream of the control state machine.

---
 rtl/pc_unit_if.sv | 32 +++
 rtl/pc_unit.sv | 115 +++++++++++
 tb/tb_pc_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Bus between the control FSM and the program-counter stage.
// traceIdx/traceAddr/traceCount carry meaning only when PC_TRACE_EN is defined.
interface pc_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int TRACE_DEPTH = 4
);
  localparam int IW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [1:0]            pcEn;
  logic                  pcAdrMuxEn;
  logic [15:0]           instruction;
  logic [ADDR_WIDTH-1:0] jumpTarget;
  logic                  C, L, F, Z, N;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [ADDR_WIDTH-1:0] linkValue;
  logic                  branchTaken;
  logic                  halted;
  logic [IW-1:0]         traceIdx;
  logic [ADDR_WIDTH-1:0] traceAddr;
  logic [IW:0]           traceCount;

  modport master (
    output pcEn, pcAdrMuxEn, instruction, jumpTarget, C, L, F, Z, N, traceIdx,
    input  pc, memAddr, linkValue, branchTaken, halted, traceAddr, traceCount
  );

  modport slave (
    input  pcEn, pcAdrMuxEn, instruction, jumpTarget, C, L, F, Z, N, traceIdx,
    output pc, memAddr, linkValue, branchTaken, halted, traceAddr, traceCount
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter: hold / increment / jump / conditional branch, JAL link capture,
// branch-to-self halt detect. Define PC_TRACE_EN to add the redirect trace buffer.
module pc_unit #(
  parameter int              ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              DISP_WIDTH   = 8,
  parameter int              TRACE_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);
  localparam int IW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] pc_q, link_q, pc_inc, disp_sx;
  logic                  taken_q, halted_q, cond, redirect, disp_zero;

  assign pc_inc    = pc_q + ADDR_WIDTH'(1);
  assign disp_sx   = {{(ADDR_WIDTH-DISP_WIDTH){bus.instruction[DISP_WIDTH-1]}},
                      bus.instruction[DISP_WIDTH-1:0]};
  assign disp_zero = (bus.instruction[DISP_WIDTH-1:0] == '0);

  always_comb begin
    cond = 1'b0;
    case (bus.instruction[11:8])
      4'b0000: cond =  bus.Z;
      4'b0001: cond = !bus.Z;
      4'b0010: cond =  bus.C;
      4'b0011: cond = !bus.C;
      4'b0100: cond =  bus.L;
      4'b0101: cond = !bus.L;
      4'b0110: cond =  bus.N;
      4'b0111: cond = !bus.N;
      4'b1000: cond =  bus.F;
      4'b1001: cond = !bus.F;
      4'b1010: cond = !bus.L && !bus.Z;
      4'b1011: cond =  bus.L ||  bus.Z;
      4'b1100: cond = !bus.N && !bus.Z;
      4'b1101: cond =  bus.N ||  bus.Z;
      4'b1110: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign redirect = (bus.pcEn == 2'b10) || ((bus.pcEn == 2'b11) && cond);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      link_q   <= '0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      taken_q <= redirect;
      case (bus.pcEn)
        2'b01: pc_q <= pc_inc;
        2'b10: begin
          pc_q   <= bus.jumpTarget;
          link_q <= pc_inc;
        end
        2'b11: begin
          if (cond) begin
            pc_q <= pc_q + disp_sx;
            // branch-to-self: the program has parked itself
            if (disp_zero) halted_q <= 1'b1;
          end else begin
            pc_q <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.linkValue   = link_q;
  assign bus.branchTaken = taken_q;
  assign bus.halted      = halted_q;
  assign bus.memAddr     = bus.pcAdrMuxEn ? bus.jumpTarget : pc_q;

  logic unused_instr;
  assign unused_instr = ^bus.instruction[15:12];

`ifdef PC_TRACE_EN
  localparam logic [IW:0] FULL = TRACE_DEPTH[IW:0];

  logic [TRACE_DEPTH-1:0][ADDR_WIDTH-1:0] trace_q;
  logic [IW-1:0]                          wrptr_q, rd_idx;
  logic [IW:0]                            cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_q <= '0;
      wrptr_q <= '0;
      cnt_q   <= '0;
    end else if (redirect) begin
      trace_q[wrptr_q] <= pc_q;
      wrptr_q          <= wrptr_q + IW'(1);
      if (cnt_q != FULL) cnt_q <= cnt_q + (IW+1)'(1);
    end
  end

  // power-of-2 depth: IW-bit wrap is the modulo
  assign rd_idx         = wrptr_q - IW'(1) - bus.traceIdx;
  assign bus.traceAddr  = trace_q[rd_idx];
  assign bus.traceCount = cnt_q;
`else
  logic [IW-1:0] unused_trace_idx;
  logic          unused_redirect;
  assign unused_trace_idx = bus.traceIdx;
  assign unused_redirect  = redirect;
  assign bus.traceAddr    = '0;
  assign bus.traceCount   = '0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural model (PC value, link, sticky halt, redirect history queue).
module tb_pc_unit;
  localparam int AW = 16;
  localparam int TD = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_WIDTH(AW), .TRACE_DEPTH(TD)) bus ();
  pc_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR('0), .DISP_WIDTH(8), .TRACE_DEPTH(TD))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int compared = 0;
  int mismatched = 0;

  logic [AW-1:0] m_pc, m_link;
  logic          m_taken, m_halted;
  logic [AW-1:0] m_hist[$];

  // base flag per pair of codes 0..9, odd code inverts it; 10..15 listed directly
  function automatic logic cond_ok(input logic [3:0] cc, input logic c, l, f, z, n);
    logic [4:0] base;
    base = {f, n, l, c, z};
    if (cc < 4'd10) return base[cc[3:1]] ^ cc[0];
    case (cc)
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [IW:0] exp_cnt();
`ifdef PC_TRACE_EN
    return (m_hist.size() > TD) ? (IW+1)'(TD) : (IW+1)'(m_hist.size());
`else
    return '0;
`endif
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int idx);
`ifdef PC_TRACE_EN
    if (idx < m_hist.size() && idx < TD) return m_hist[m_hist.size()-1-idx];
`endif
    return '0;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_link = '0; m_taken = 1'b0; m_halted = 1'b0;
    m_hist.delete();
  endtask

  // drive one cycle (flags packed {C,L,F,Z,N}), advance the model, sample #1 after the edge
  task automatic step(input logic [1:0] en, input logic [15:0] instr,
                      input logic [AW-1:0] jt, input logic [4:0] fl);
    logic t;
    logic [7:0] d;
    bus.pcEn = en; bus.instruction = instr; bus.jumpTarget = jt;
    {bus.C, bus.L, bus.F, bus.Z, bus.N} = fl;
    d = instr[7:0];
    t = (en == 2'd2) || (en == 2'd3 && cond_ok(instr[11:8], fl[4], fl[3], fl[2], fl[1], fl[0]));
    if (t) m_hist.push_back(m_pc);
    if (en == 2'd2) begin
      m_link = AW'(m_pc + 1);
      m_pc   = jt;
    end else if (en == 2'd3 && t) begin
      if (d == 8'd0) m_halted = 1'b1;
      m_pc = AW'(int'(m_pc) + int'($signed(d)));
    end else if (en != 2'd0) begin
      m_pc = AW'(m_pc + 1);
    end
    m_taken = t;
    @(posedge clk); #1;
  endtask

  task automatic async_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.pcEn = 2'b01; bus.pcAdrMuxEn = 1'b0; bus.instruction = '0; bus.jumpTarget = '0;
    {bus.C, bus.L, bus.F, bus.Z, bus.N} = '0; bus.traceIdx = '0;
    model_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    if (bus.pc !== 16'h0000) begin mismatched++; $display("FAIL reset_pc: got %h want 0000", bus.pc); end
    compared++;
    if (bus.linkValue !== 16'h0000) begin mismatched++; $display("FAIL reset_link: got %h want 0000", bus.linkValue); end
    compared++;
    if (bus.halted !== 1'b0 || bus.branchTaken !== 1'b0) begin
      mismatched++; $display("FAIL reset_flags: halted %b taken %b want 0 0", bus.halted, bus.branchTaken);
    end
    compared++;
    if (bus.traceCount !== '0) begin mismatched++; $display("FAIL reset_tcount: got %0d want 0", bus.traceCount); end
    compared++;
    reset = 1'b1;
    repeat (3) step(2'b01, '0, '0, '0);
    if (bus.pc !== 16'h0003) begin mismatched++; $display("FAIL count3: got %h want 0003", bus.pc); end
    compared++;
  endtask

  task automatic test_wrap();
    step(2'b10, '0, 16'hFFFF, '0);
    step(2'b01, '0, '0, '0);
    if (bus.pc !== 16'h0000 || bus.branchTaken !== 1'b0) begin
      mismatched++; $display("FAIL wrap: pc %h taken %b want 0000 0", bus.pc, bus.branchTaken);
    end
    compared++;
  endtask

  task automatic test_jump();
    step(2'b10, '0, 16'h0010, '0);
    step(2'b10, '0, 16'h0200, '0);
    if (bus.pc !== 16'h0200 || bus.linkValue !== 16'h0011 || bus.branchTaken !== 1'b1) begin
      mismatched++;
      $display("FAIL jump: pc %h link %h taken %b want 0200 0011 1", bus.pc, bus.linkValue, bus.branchTaken);
    end
    compared++;
    step(2'b00, '0, 16'h1234, '0);
    if (bus.pc !== 16'h0200 || bus.branchTaken !== 1'b0 || bus.linkValue !== 16'h0011) begin
      mismatched++; $display("FAIL jump_hold: pc %h taken %b link %h want 0200 0 0011",
                             bus.pc, bus.branchTaken, bus.linkValue);
    end
    compared++;
  endtask

  task automatic test_bcond();
    step(2'b10, '0, 16'h0020, '0);
    step(2'b11, 16'h00FC, '0, 5'b00010);
    if (bus.pc !== 16'h001C || bus.branchTaken !== 1'b1) begin
      mismatched++; $display("FAIL beq_taken: pc %h taken %b want 001C 1", bus.pc, bus.branchTaken);
    end
    compared++;
    step(2'b10, '0, 16'h0020, '0);
    step(2'b11, 16'h00FC, '0, 5'b00000);
    if (bus.pc !== 16'h0021 || bus.branchTaken !== 1'b0) begin
      mismatched++; $display("FAIL beq_fall: pc %h taken %b want 0021 0", bus.pc, bus.branchTaken);
    end
    compared++;
  endtask

  task automatic test_memaddr();
    logic [AW-1:0] jt;
    jt = AW'($urandom);
    bus.jumpTarget = jt; bus.pcAdrMuxEn = 1'b1; #1;
    if (bus.memAddr !== jt) begin mismatched++; $display("FAIL memaddr_jt: got %h want %h", bus.memAddr, jt); end
    compared++;
    bus.pcAdrMuxEn = 1'b0; #1;
    if (bus.memAddr !== m_pc) begin mismatched++; $display("FAIL memaddr_pc: got %h want %h", bus.memAddr, m_pc); end
    compared++;
  endtask

  task automatic test_random();
    async_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) async_reset();
      bus.pcAdrMuxEn = 1'($urandom);
      bus.traceIdx   = IW'($urandom);
      step(2'($urandom), 16'($urandom), AW'($urandom), 5'($urandom));
      if (bus.pc !== m_pc) begin mismatched++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc, m_pc); end
      compared++;
      if (bus.linkValue !== m_link) begin mismatched++; $display("FAIL rnd_link[%0d]: got %h want %h", i, bus.linkValue, m_link); end
      compared++;
      if (bus.branchTaken !== m_taken || bus.halted !== m_halted) begin
        mismatched++; $display("FAIL rnd_flags[%0d]: taken %b halted %b want %b %b",
                               i, bus.branchTaken, bus.halted, m_taken, m_halted);
      end
      compared++;
      if (bus.memAddr !== (bus.pcAdrMuxEn ? bus.jumpTarget : m_pc)) begin
        mismatched++; $display("FAIL rnd_memaddr[%0d]: got %h", i, bus.memAddr);
      end
      compared++;
      if (bus.traceCount !== exp_cnt() || bus.traceAddr !== exp_addr(int'(bus.traceIdx))) begin
        mismatched++; $display("FAIL rnd_trace[%0d]: cnt %0d addr %h want %0d %h", i,
                               bus.traceCount, bus.traceAddr, exp_cnt(), exp_addr(int'(bus.traceIdx)));
      end
      compared++;
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] p;
    async_reset();
    step(2'b10, '0, 16'h0456, '0);
    p = bus.pc;
    if (bus.halted !== 1'b0) begin mismatched++; $display("FAIL halt_pre: got %b want 0", bus.halted); end
    compared++;
    step(2'b11, 16'h0E00, '0, '0);
    if (bus.pc !== 16'h0456 || bus.halted !== 1'b1 || bus.branchTaken !== 1'b1) begin
      mismatched++; $display("FAIL halt_set: pc %h halted %b taken %b want 0456 1 1", bus.pc, bus.halted, bus.branchTaken);
    end
    compared++;
    step(2'b01, '0, '0, '0);
    if (bus.pc !== AW'(p + 1) || bus.halted !== 1'b1) begin
      mismatched++; $display("FAIL halt_sticky: pc %h halted %b want 0457 1", bus.pc, bus.halted);
    end
    compared++;
    step(2'b11, 16'h0F00, '0, 5'b11111);
    if (bus.pc !== 16'h0458 || bus.branchTaken !== 1'b0) begin
      mismatched++; $display("FAIL never_cond: pc %h taken %b want 0458 0", bus.pc, bus.branchTaken);
    end
    compared++;
  endtask

  task automatic test_trace();
    logic [AW-1:0] tgt[5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    async_reset();
    for (int i = 0; i < 5; i++) step(2'b10, '0, tgt[i], '0);
    bus.traceIdx = 2'd0; #1;
`ifdef PC_TRACE_EN
    if (bus.traceCount !== 3'd4 || bus.traceAddr !== 16'h0400) begin
      mismatched++; $display("FAIL trace_newest: cnt %0d addr %h want 4 0400", bus.traceCount, bus.traceAddr);
    end
`else
    if (bus.traceCount !== 3'd0 || bus.traceAddr !== 16'h0000) begin
      mismatched++; $display("FAIL trace_off: cnt %0d addr %h want 0 0000", bus.traceCount, bus.traceAddr);
    end
`endif
    compared++;
    bus.traceIdx = 2'd3; #1;
    if (bus.traceAddr !== exp_addr(3)) begin
      mismatched++; $display("FAIL trace_oldest: got %h want %h", bus.traceAddr, exp_addr(3));
    end
    compared++;
    step(2'b10, '0, 16'h0600, '0);
    step(2'b10, '0, 16'h0700, '0);
    async_reset();
    bus.traceIdx = 2'd0; #1;
    if (bus.traceCount !== '0 || bus.traceAddr !== '0 || bus.pc !== '0) begin
      mismatched++; $display("FAIL trace_reset: cnt %0d addr %h pc %h want 0 0000 0000",
                             bus.traceCount, bus.traceAddr, bus.pc);
    end
    compared++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_jump();
    test_bcond();
    test_memaddr();
    test_random();
    test_halt();
    test_trace();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
